// File: rtl/inst_cache_nway.sv
// N-way set-associative instruction cache with round-robin replacement,
// a sequential flush sweep and saturating hit/miss counters.
module inst_cache_nway #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 7,
  parameter int TAG_HI    = 17,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cache_query,
  input  logic [31:0]          query_addr,
  input  logic                 cache_enable,
  input  logic [31:0]          inst_addr,
  input  logic [31:0]          inst_cache_i,
  input  logic                 flush,
  output logic                 busy,
  output logic                 inst_hit_o,
  output logic [31:0]          inst_cache_o,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int SETS = 1 << SET_BITS;
  localparam int TW   = TAG_HI - SET_BITS - 1;
  localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [WAYS-1:0] valid_q [SETS];
  logic [PW-1:0]   ptr_q   [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS];

  logic [0:0]          state_q, state_d;
  logic [SET_BITS-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  logic [SET_BITS-1:0] q_set, f_set;
  logic [TW-1:0]       q_tag, f_tag;
  logic                hit;
  logic [31:0]         rdata;
  logic                match, inv, adv, fill_go, lookup;
  logic [PW-1:0]       match_way, inv_way, victim, ptr_nxt;
  logic                unused_bits;

  assign q_set = query_addr[SET_BITS+1:2];
  assign q_tag = query_addr[TAG_HI:SET_BITS+2];
  assign f_set = inst_addr[SET_BITS+1:2];
  assign f_tag = inst_addr[TAG_HI:SET_BITS+2];

  assign unused_bits = ^{query_addr[1:0], inst_addr[1:0],
                         query_addr[31:TAG_HI+1],
                         inst_addr[31:TAG_HI+1]};

  assign busy     = (state_q == S_SWEEP);
  assign lookup   = cache_query && !busy;
  assign fill_go  = cache_enable && !busy;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[q_set][w] && tag_q[q_set][w] == q_tag) begin
        hit   = 1'b1;
        rdata = data_q[q_set][w];
      end
    end
  end

  assign inst_hit_o   = lookup && hit;
  assign inst_cache_o = inst_hit_o ? rdata : 32'h0;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    match     = 1'b0;
    match_way = '0;
    inv       = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[f_set][w] && tag_q[f_set][w] == f_tag) begin
        match     = 1'b1;
        match_way = PW'(w);
      end
      if (!valid_q[f_set][w]) begin
        inv     = 1'b1;
        inv_way = PW'(w);
      end
    end
    victim  = match ? match_way : (inv ? inv_way : ptr_q[f_set]);
    adv     = !match && !inv;
    ptr_nxt = (ptr_q[f_set] == PW'(WAYS - 1)) ? '0
            : ptr_q[f_set] + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (busy) begin
        valid_q[idx_q] <= '0;
        ptr_q[idx_q]   <= '0;
      end else if (fill_go) begin
        valid_q[f_set][victim] <= 1'b1;
        if (adv) ptr_q[f_set] <= ptr_nxt;
      end
      if (lookup) begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  // Payload arrays are qualified by valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_go) begin
      tag_q[f_set][victim]  <= f_tag;
      data_q[f_set][victim] <= inst_cache_i;
    end
  end

endmodule

// File: tb/tb_inst_cache_nway.sv
// Directed testbench for inst_cache_nway (2-way, 128 sets) with a
// second 4-bit-counter instance sharing the same stimulus.
module tb_inst_cache_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cache_query = 1'b0;
  logic [31:0] query_addr = '0;
  logic        cache_enable = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_cache_i = '0;
  logic        flush = 1'b0;

  logic        busy, inst_hit_o;
  logic [31:0] inst_cache_o, hit_cnt, miss_cnt;
  logic        busy4, hit4;
  logic [31:0] data4;
  logic [3:0]  hit_cnt4, miss_cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_cache_nway dut (
    .clk(clk), .rst(rst),
    .cache_query(cache_query), .query_addr(query_addr),
    .cache_enable(cache_enable), .inst_addr(inst_addr),
    .inst_cache_i(inst_cache_i), .flush(flush),
    .busy(busy), .inst_hit_o(inst_hit_o),
    .inst_cache_o(inst_cache_o),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  inst_cache_nway #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .cache_query(cache_query), .query_addr(query_addr),
    .cache_enable(cache_enable), .inst_addr(inst_addr),
    .inst_cache_i(inst_cache_i), .flush(flush),
    .busy(busy4), .inst_hit_o(hit4),
    .inst_cache_o(data4),
    .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    cache_enable = 1'b1;
    inst_addr    = a;
    inst_cache_i = d;
    tick();
    cache_enable = 1'b0;
  endtask

  task automatic look(input logic [31:0] a,
                      output logic h, output logic [31:0] d);
    cache_query = 1'b1;
    query_addr  = a;
    #1;
    h = inst_hit_o;
    d = inst_cache_o;
    tick();
    cache_query = 1'b0;
  endtask

  task automatic test_reset();
    logic h;
    logic [31:0] d;
    do_reset();
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b hit=%0d miss=%0d want 0/0/0",
               busy, hit_cnt, miss_cnt);
    end
    look(32'h100, h, d);
    checks++;
    if (h !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL reset_lookup hit=%b data=%h want 0/0", h, d);
    end
    checks++;
    if (miss_cnt !== 1 || hit_cnt !== 0) begin
      errors++;
      $display("FAIL reset_miss_cnt miss=%0d hit=%0d want 1/0",
               miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_fill_hit();
    do_reset();
    cache_enable = 1'b1;
    inst_addr    = 32'h100;
    inst_cache_i = 32'hDEADBEEF;
    cache_query  = 1'b1;
    query_addr   = 32'h100;
    #1;
    checks++;
    if (inst_hit_o !== 1'b0 || inst_cache_o !== 32'h0) begin
      errors++;
      $display("FAIL same_cycle_fill hit=%b data=%h want 0/0",
               inst_hit_o, inst_cache_o);
    end
    tick();
    cache_enable = 1'b0;
    #1;
    checks++;
    if (inst_hit_o !== 1'b1 || inst_cache_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL next_cycle_hit hit=%b data=%h want 1/deadbeef",
               inst_hit_o, inst_cache_o);
    end
    tick();
    cache_query = 1'b0;
    checks++;
    if (hit_cnt !== 1 || miss_cnt !== 1) begin
      errors++;
      $display("FAIL fill_counters hit=%0d miss=%0d want 1/1",
               hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic h;
    logic [31:0] d;
    do_reset();
    fill(32'h000, 32'hAAAA0000);
    fill(32'h200, 32'hBBBB0000);
    fill(32'h400, 32'hCCCC0000);
    look(32'h000, h, d);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL rr_evict_000 hit=%b want 0", h);
    end
    look(32'h200, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hBBBB0000) begin
      errors++;
      $display("FAIL rr_hit_200 hit=%b data=%h want 1/bbbb0000", h, d);
    end
    look(32'h400, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hCCCC0000) begin
      errors++;
      $display("FAIL rr_hit_400 hit=%b data=%h want 1/cccc0000", h, d);
    end
    fill(32'h600, 32'hDDDD0000);
    look(32'h200, h, d);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL rr_evict_200 hit=%b want 0", h);
    end
    look(32'h400, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hCCCC0000) begin
      errors++;
      $display("FAIL rr_keep_400 hit=%b data=%h want 1/cccc0000", h, d);
    end
    look(32'h600, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hDDDD0000) begin
      errors++;
      $display("FAIL rr_hit_600 hit=%b data=%h want 1/dddd0000", h, d);
    end
  endtask

  task automatic test_refill();
    logic h;
    logic [31:0] d;
    do_reset();
    fill(32'h000, 32'hAAAA0000);
    fill(32'h000, 32'hEEEE0000);
    look(32'h000, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hEEEE0000) begin
      errors++;
      $display("FAIL refill_data hit=%b data=%h want 1/eeee0000", h, d);
    end
    fill(32'h200, 32'hBBBB0000);
    fill(32'h400, 32'hCCCC0000);
    look(32'h000, h, d);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL refill_evict hit=%b data=%h want 0", h, d);
    end
    look(32'h200, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hBBBB0000) begin
      errors++;
      $display("FAIL refill_keep_200 hit=%b data=%h want 1/bbbb0000",
               h, d);
    end
    look(32'h400, h, d);
    checks++;
    if (h !== 1'b1 || d !== 32'hCCCC0000) begin
      errors++;
      $display("FAIL refill_hit_400 hit=%b data=%h want 1/cccc0000",
               h, d);
    end
  endtask

  task automatic test_flush();
    logic h, any_hit;
    logic [31:0] d;
    int n;
    do_reset();
    fill(32'h000, 32'h11110000);
    fill(32'h004, 32'h22220000);
    fill(32'h008, 32'h33330000);
    fill(32'h200, 32'h44440000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_rise busy=%b want 1", busy);
    end
    n = 0;
    any_hit = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      cache_query  = 1'b1;
      query_addr   = 32'h004;
      cache_enable = (n == 127);
      inst_addr    = 32'h00C;
      inst_cache_i = 32'h55550000;
      flush        = (n == 5);
      #1;
      any_hit = any_hit | inst_hit_o | (inst_cache_o != 32'h0);
      tick();
      n++;
    end
    cache_query  = 1'b0;
    cache_enable = 1'b0;
    flush        = 1'b0;
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL flush_busy_len cycles=%0d want 128", n);
    end
    checks++;
    if (any_hit !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_lookup hit_seen=%b want 0", any_hit);
    end
    checks++;
    if (hit_cnt !== 0 || miss_cnt !== 0) begin
      errors++;
      $display("FAIL flush_no_count hit=%0d miss=%0d want 0/0",
               hit_cnt, miss_cnt);
    end
    any_hit = 1'b0;
    look(32'h000, h, d); any_hit = any_hit | h;
    look(32'h004, h, d); any_hit = any_hit | h;
    look(32'h008, h, d); any_hit = any_hit | h;
    look(32'h200, h, d); any_hit = any_hit | h;
    checks++;
    if (any_hit !== 1'b0) begin
      errors++;
      $display("FAIL flush_lines_gone hit_seen=%b want 0", any_hit);
    end
    look(32'h00C, h, d);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill_dropped hit=%b want 0", h);
    end
    checks++;
    if (miss_cnt !== 5 || hit_cnt !== 0) begin
      errors++;
      $display("FAIL flush_after_cnt miss=%0d hit=%0d want 5/0",
               miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic h;
    logic [31:0] d;
    do_reset();
    fill(32'h100, 32'h12345678);
    look(32'h100, h, d);
    look(32'h300, h, d);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1 || hit_cnt !== 1 || miss_cnt !== 1) begin
      errors++;
      $display("FAIL mid_sweep_pre busy=%b hit=%0d miss=%0d want 1/1/1",
               busy, hit_cnt, miss_cnt);
    end
    fill(32'h100, 32'h12345678);
    do_reset();
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin
      errors++;
      $display("FAIL mid_sweep_rst busy=%b hit=%0d miss=%0d want 0/0/0",
               busy, hit_cnt, miss_cnt);
    end
    look(32'h100, h, d);
    checks++;
    if (h !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL mid_sweep_miss hit=%b data=%h want 0/0", h, d);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    fill(32'h100, 32'hCAFEF00D);
    cache_query = 1'b1;
    query_addr  = 32'h100;
    repeat (20) tick();
    cache_query = 1'b0;
    checks++;
    if (hit_cnt !== 20) begin
      errors++;
      $display("FAIL sat_wide hit=%0d want 20", hit_cnt);
    end
    checks++;
    if (hit_cnt4 !== 4'd15 || miss_cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL sat_narrow hit=%0d miss=%0d want 15/0",
               hit_cnt4, miss_cnt4);
    end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_round_robin();
    test_refill();
    test_flush();
    test_reset_mid_sweep();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_cache_nway.md
INST_CACHE_NWAY -- requirements
Module: inst_cache_nway

Interface
REQ-001 Parameters: WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameters: SET_BITS, default 7, log2 of set count (SETS = 2^SET_BITS).
REQ-003 Parameters: TAG_HI, default 17, top address bit used as tag; the tag is addr[TAG_HI : SET_BITS+2].
REQ-004 Parameters: CNT_WIDTH, default 32, width of the hit and miss counters.
REQ-005 Clock and reset: reset rst, synchronous, active-high; clock clk.
REQ-006 Port: clk  in  1  clock.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: cache_query  in  1  lookup request this cycle.
REQ-009 Port: query_addr  in  32  lookup address; the set is query_addr[SET_BITS+1:2].
REQ-010 Port: cache_enable  in  1  fill request this cycle.
REQ-011 Port: inst_addr  in  32  fill address.
REQ-012 Port: inst_cache_i  in  32  fill data.
REQ-013 Port: flush  in  1  single-cycle pulse that invalidates the whole cache.
REQ-014 Port: busy  out  1  flush sweep in progress.
REQ-015 Port: inst_hit_o  out  1  lookup hit.
REQ-016 Port: inst_cache_o  out  32  hit data; 32'h0 when there is no hit.
REQ-017 Port: hit_cnt  out  CNT_WIDTH  count of lookups that hit.
REQ-018 Port: miss_cnt  out  CNT_WIDTH  count of lookups that missed.

Function
REQ-019 Lookup SHALL be combinational with zero latency: inst_hit_o=1 iff cache_query=1, busy=0, and some way of the set is valid with a matching tag.
REQ-020 On a hit, inst_cache_o SHALL carry that way's data; more than one matching way SHALL never occur (see REQ-023).
REQ-021 A fill SHALL write data, tag and valid at the posedge where cache_enable=1 and busy=0; fills while busy=1 SHALL be dropped.
REQ-022 Victim selection SHALL take the lowest-index invalid way; if every way is valid, it SHALL take the way given by the set's round-robin pointer, and the pointer SHALL then advance modulo WAYS.
REQ-023 If the fill tag already exists, valid, in the set, that way SHALL be overwritten and the pointer left unchanged.
REQ-024 Filling an invalid way SHALL leave the pointer unchanged.
REQ-025 When a query and a fill hit the same set in the same cycle, the query SHALL see the pre-write contents; the new line SHALL be visible from the next cycle.
REQ-026 WAYS=1 SHALL behave as direct-mapped, with the pointer constant 0.
REQ-027 Flush FSM, IDLE state: a flush pulse SHALL move the FSM to SWEEP with the index at 0 and busy=1 from the next cycle.
REQ-028 Flush FSM, SWEEP state: each cycle SHALL clear the valid bits of all ways and the pointer of set[index], then increment the index.
REQ-029 After clearing set SETS-1, the FSM SHALL return to IDLE and busy SHALL be 0 on the following cycle; a sweep therefore takes exactly SETS cycles.
REQ-030 A flush pulse during SWEEP SHALL be ignored; it SHALL not restart the sweep.
REQ-031 Each cycle with cache_query=1 and busy=0, hit_cnt SHALL increment on a hit and miss_cnt SHALL increment on a miss.
REQ-032 Both counters SHALL saturate at all-ones and SHALL not wrap.
REQ-033 Lookups while busy=1 SHALL return a miss and SHALL not be counted.

Reset
REQ-034 When rst=1 at a posedge, the block SHALL in that single cycle clear all valid bits and all pointers, set the FSM to IDLE and busy=0, and zero hit_cnt and miss_cnt.
REQ-035 Reset SHALL take priority over flush and fill.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep.
REQ-037 Data and tag arrays SHALL need no reset.
REQ-038 After reset and until a fill, every lookup SHALL return inst_hit_o=0 and inst_cache_o=32'h0.

Verification
REQ-039 Scenario: reset, then query 0x100 -> hit=0, data=0, miss_cnt=1.
REQ-040 Scenario: fill 0x100=0xDEADBEEF, then query 0x100 the next cycle -> hit=1, data=0xDEADBEEF, hit_cnt=1; a query in the same cycle as the fill -> miss.
REQ-041 Scenario (WAYS=2, SET_BITS=7): fill 0x000=A, 0x200=B, 0x400=C, all set 0 -> 0x000 misses; 0x200 hits B; 0x400 hits C.
REQ-042 Scenario: the same three fills plus 0x600=D -> 0x200 misses; 0x400 and 0x600 hit.
REQ-043 Scenario: fill 0x000=A, then fill 0x000=E -> query 0x000 returns E; filling 0x200 then 0x400 evicts 0x000 and never causes a double hit.
REQ-044 Scenario: fill 4 lines, pulse flush -> busy=1 for exactly 128 cycles; queries and fills during busy give hit=0, no count change and no fill; after busy falls all 4 lines miss.
REQ-045 Scenario: rst pulsed at cycle 10 of a sweep -> busy=0 next cycle, counters=0, all lines miss.
REQ-046 Scenario: CNT_WIDTH=4 with 20 hits -> hit_cnt holds at 15.
